// File: rtl/instr_fetch_decoder.sv
// instr_fetch_decoder
//   Byte-serial instruction decoder. Opcode and argument words arrive one per
//   cycle on a valid/ready stream. They are assembled into one decoded
//   instruction, which is held on a registered output until execute takes it.
//
// Ports
//   CLK, RST           clock (rising edge), asynchronous active-high reset
//   FLUSH              synchronous discard of any partial or held instruction
//   IN_VALID/IN_READY  fetch-side handshake, IN_DATA carries one word
//   OUT_VALID/OUT_READY execute-side handshake
//   OUT_OPCODE         opcode word
//   OUT_GROUP          opcode MSBs (group field)
//   OUT_ARGS           argument words, last word in the LSBs, unused words 0
//   OUT_NARGS          argument count taken from LEN_MAP (0 when illegal)
//   OUT_ILLEGAL        group masked illegal, or its length exceeds ARG_BYTES
//   DEC_COUNT          wrapping count of delivered instructions
module instr_fetch_decoder #(
  parameter int DATA_W    = 8,
  parameter int GROUP_W   = 3,
  parameter int ARG_BYTES = 2,
  parameter logic [2*(1<<GROUP_W)-1:0] LEN_MAP      = 16'b00_00_00_00_10_01_10_00,
  parameter logic [(1<<GROUP_W)-1:0]   ILLEGAL_MASK = 8'b1111_0000
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        FLUSH,
  input  logic                        IN_VALID,
  output logic                        IN_READY,
  input  logic [DATA_W-1:0]           IN_DATA,
  output logic                        OUT_VALID,
  input  logic                        OUT_READY,
  output logic [DATA_W-1:0]           OUT_OPCODE,
  output logic [GROUP_W-1:0]          OUT_GROUP,
  output logic [ARG_BYTES*DATA_W-1:0] OUT_ARGS,
  output logic [1:0]                  OUT_NARGS,
  output logic                        OUT_ILLEGAL,
  output logic [15:0]                 DEC_COUNT
);

  localparam int         AW       = ARG_BYTES * DATA_W;
  localparam logic [1:0] MAX_ARGS = 2'(ARG_BYTES);

  typedef enum logic [1:0] {OPC, ARG, HOLD} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] opcode;
    logic [AW-1:0]     args;
    logic [1:0]        nargs;
    logic              illegal;
  } insn_t;

  state_t      state, state_n;
  insn_t       cur, cur_n;   // instruction being assembled
  insn_t       out_q;        // instruction presented to execute
  logic [1:0]  rem, rem_n;   // argument words still to collect
  logic        vld, vld_n;
  logic [15:0] cnt, cnt_n;
  logic        load_out;

  // Decode of the incoming word as if it were an opcode.
  logic [GROUP_W-1:0] in_group;
  logic [1:0]         in_len;
  logic               in_ill;

  assign in_group = IN_DATA[DATA_W-1 -: GROUP_W];
  assign in_len   = LEN_MAP[2*in_group +: 2];
  assign in_ill   = ILLEGAL_MASK[in_group] || (in_len > MAX_ARGS);

  // Ready bypass: while holding, a word may still be taken in the same cycle
  // that execute takes the held instruction, so back-to-back instructions
  // stream at one word per cycle.
  assign IN_READY = !RST && !FLUSH && ((state != HOLD) || OUT_READY);

  logic in_fire, out_fire;
  assign in_fire  = IN_VALID && IN_READY;
  assign out_fire = vld && OUT_READY;

  always_comb begin
    state_n  = state;
    cur_n    = cur;
    rem_n    = rem;
    vld_n    = vld;
    cnt_n    = cnt;
    load_out = 1'b0;
    if (FLUSH) begin
      state_n = OPC;
      vld_n   = 1'b0;
    end else begin
      if (state == HOLD && out_fire) begin
        cnt_n   = cnt + 16'd1;
        state_n = OPC;
        vld_n   = 1'b0;
      end
      // New opcode: from OPC, or from HOLD through the bypass.
      if (in_fire && state != ARG) begin
        cur_n.opcode  = IN_DATA;
        cur_n.args    = '0;
        cur_n.illegal = in_ill;
        cur_n.nargs   = in_ill ? 2'd0 : in_len;
        rem_n         = cur_n.nargs;
        if (cur_n.nargs == 2'd0) begin
          state_n  = HOLD;
          vld_n    = 1'b1;
          load_out = 1'b1;
        end else begin
          state_n = ARG;
        end
      end
      if (in_fire && state == ARG) begin
        cur_n.args = (cur.args << DATA_W) | AW'(IN_DATA);
        rem_n      = rem - 2'd1;
        if (rem == 2'd1) begin
          state_n  = HOLD;
          vld_n    = 1'b1;
          load_out = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= OPC;
      cur   <= '0;
      rem   <= 2'd0;
      vld   <= 1'b0;
      cnt   <= 16'd0;
      out_q <= '0;
    end else begin
      state <= state_n;
      cur   <= cur_n;
      rem   <= rem_n;
      vld   <= vld_n;
      cnt   <= cnt_n;
      if (load_out) out_q <= cur_n;
    end
  end

  assign OUT_VALID   = vld;
  assign OUT_OPCODE  = out_q.opcode;
  assign OUT_GROUP   = out_q.opcode[DATA_W-1 -: GROUP_W];
  assign OUT_ARGS    = out_q.args;
  assign OUT_NARGS   = out_q.nargs;
  assign OUT_ILLEGAL = out_q.illegal;
  assign DEC_COUNT   = cnt;

endmodule

// File: tb/tb_instr_fetch_decoder.sv
module tb_instr_fetch_decoder;
  localparam logic [15:0] LEN_MAP_REF = 16'b00_00_00_00_10_01_10_00;
  localparam logic [7:0]  ILL_REF     = 8'hF0;

  logic        CLK = 1'b0;
  logic        RST, FLUSH, IN_VALID, IN_READY, OUT_VALID, OUT_READY, OUT_ILLEGAL;
  logic [7:0]  IN_DATA, OUT_OPCODE;
  logic [2:0]  OUT_GROUP;
  logic [15:0] OUT_ARGS, DEC_COUNT;
  logic [1:0]  OUT_NARGS;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [7:0]  op;
    logic [15:0] args;
    logic [1:0]  nargs;
    logic        ill;
  } exp_t;

  always #5 CLK = ~CLK;

  instr_fetch_decoder dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_OPCODE(OUT_OPCODE), .OUT_GROUP(OUT_GROUP), .OUT_ARGS(OUT_ARGS),
    .OUT_NARGS(OUT_NARGS), .OUT_ILLEGAL(OUT_ILLEGAL), .DEC_COUNT(DEC_COUNT)
  );

  task automatic step;
    @(posedge CLK); #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d);
    IN_VALID = v;
    IN_DATA  = d;
  endtask

  task automatic do_reset;
    RST = 1'b1; FLUSH = 1'b0; OUT_READY = 1'b0; drive(1'b0, 8'h00);
    #3; RST = 1'b0;
    step();
  endtask

  task automatic test_reset;
    RST = 1'b1; FLUSH = 1'b0; OUT_READY = 1'b0; drive(1'b0, 8'h00);
    #2;
    tests++;
    if ({OUT_VALID, OUT_OPCODE, OUT_ARGS, OUT_NARGS, OUT_ILLEGAL, DEC_COUNT} !== 44'h0) begin
      fails++;
      $display("FAIL reset_outputs: got valid=%0b op=%h args=%h nargs=%0d ill=%0b cnt=%0d want all 0",
               OUT_VALID, OUT_OPCODE, OUT_ARGS, OUT_NARGS, OUT_ILLEGAL, DEC_COUNT);
    end
    RST = 1'b0; #1;
    tests++;
    if (IN_READY !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", IN_READY); end
    step();
  endtask

  task automatic test_single;
    do_reset();
    OUT_READY = 1'b1; drive(1'b1, 8'h05);
    step(); drive(1'b0, 8'h00);
    tests++;
    if ({OUT_VALID, OUT_OPCODE, OUT_ARGS, OUT_NARGS, OUT_ILLEGAL} !== {1'b1, 8'h05, 16'h0000, 2'd0, 1'b0}) begin
      fails++;
      $display("FAIL single_decode: got valid=%0b op=%h args=%h nargs=%0d ill=%0b want 1 05 0000 0 0",
               OUT_VALID, OUT_OPCODE, OUT_ARGS, OUT_NARGS, OUT_ILLEGAL);
    end
    step();
    tests++;
    if ({OUT_VALID, DEC_COUNT} !== {1'b0, 16'd1}) begin
      fails++; $display("FAIL single_count: got valid=%0b cnt=%0d want 0 1", OUT_VALID, DEC_COUNT);
    end
  endtask

  task automatic test_back_to_back;
    do_reset();
    OUT_READY = 1'b1;
    drive(1'b1, 8'h21); step();
    drive(1'b1, 8'hAB); step();
    tests++;
    if (OUT_VALID !== 1'b0) begin fails++; $display("FAIL b2b_partial_valid: got %b want 0", OUT_VALID); end
    drive(1'b1, 8'hCD); step();
    drive(1'b0, 8'h00);
    tests++;
    if ({OUT_VALID, OUT_OPCODE, OUT_GROUP, OUT_ARGS, OUT_NARGS} !== {1'b1, 8'h21, 3'd1, 16'hABCD, 2'd2}) begin
      fails++;
      $display("FAIL b2b_decode: got valid=%0b op=%h grp=%0d args=%h nargs=%0d want 1 21 1 abcd 2",
               OUT_VALID, OUT_OPCODE, OUT_GROUP, OUT_ARGS, OUT_NARGS);
    end
    step();
    tests++;
    if (DEC_COUNT !== 16'd1) begin fails++; $display("FAIL b2b_count: got %0d want 1", DEC_COUNT); end
  endtask

  task automatic test_stall;
    do_reset();
    OUT_READY = 1'b0;
    drive(1'b1, 8'h41); step();
    drive(1'b1, 8'h7F); step();
    drive(1'b1, 8'h22);
    for (int i = 0; i < 5; i++) begin
      #1;
      tests++;
      if ({IN_READY, OUT_VALID, OUT_ARGS, OUT_NARGS} !== {1'b0, 1'b1, 16'h007F, 2'd1}) begin
        fails++;
        $display("FAIL stall_hold: cycle %0d got rdy=%b valid=%b args=%h nargs=%0d want 0 1 007f 1",
                 i, IN_READY, OUT_VALID, OUT_ARGS, OUT_NARGS);
      end
      step();
    end
    OUT_READY = 1'b1; #1;
    tests++;
    if (IN_READY !== 1'b1) begin fails++; $display("FAIL stall_bypass_ready: got %b want 1", IN_READY); end
    step();
    tests++;
    if ({OUT_VALID, DEC_COUNT} !== {1'b0, 16'd1}) begin
      fails++; $display("FAIL stall_release: got valid=%b cnt=%0d want 0 1", OUT_VALID, DEC_COUNT);
    end
    drive(1'b1, 8'h12); step();
    drive(1'b1, 8'h34); step();
    drive(1'b0, 8'h00);
    tests++;
    if ({OUT_VALID, OUT_OPCODE, OUT_ARGS, OUT_NARGS} !== {1'b1, 8'h22, 16'h1234, 2'd2}) begin
      fails++;
      $display("FAIL stall_next: got valid=%b op=%h args=%h nargs=%0d want 1 22 1234 2",
               OUT_VALID, OUT_OPCODE, OUT_ARGS, OUT_NARGS);
    end
    step();
    tests++;
    if (DEC_COUNT !== 16'd2) begin fails++; $display("FAIL stall_count: got %0d want 2", DEC_COUNT); end
  endtask

  task automatic test_illegal;
    do_reset();
    OUT_READY = 1'b0;
    drive(1'b1, 8'h9C); step();
    drive(1'b0, 8'h00);
    tests++;
    if ({OUT_VALID, OUT_OPCODE, OUT_GROUP, OUT_NARGS, OUT_ILLEGAL} !== {1'b1, 8'h9C, 3'd4, 2'd0, 1'b1}) begin
      fails++;
      $display("FAIL illegal_decode: got valid=%b op=%h grp=%0d nargs=%0d ill=%b want 1 9c 4 0 1",
               OUT_VALID, OUT_OPCODE, OUT_GROUP, OUT_NARGS, OUT_ILLEGAL);
    end
    OUT_READY = 1'b1; drive(1'b1, 8'h00); step();
    drive(1'b0, 8'h00);
    tests++;
    if ({OUT_VALID, OUT_OPCODE, OUT_ILLEGAL, DEC_COUNT} !== {1'b1, 8'h00, 1'b0, 16'd1}) begin
      fails++;
      $display("FAIL illegal_next_opcode: got valid=%b op=%h ill=%b cnt=%0d want 1 00 0 1",
               OUT_VALID, OUT_OPCODE, OUT_ILLEGAL, DEC_COUNT);
    end
    step();
    tests++;
    if ({OUT_VALID, DEC_COUNT} !== {1'b0, 16'd2}) begin
      fails++; $display("FAIL illegal_count: got valid=%b cnt=%0d want 0 2", OUT_VALID, DEC_COUNT);
    end
  endtask

  task automatic test_flush;
    do_reset();
    OUT_READY = 1'b1;
    drive(1'b1, 8'h21); step();
    drive(1'b1, 8'h11); step();
    FLUSH = 1'b1; drive(1'b1, 8'h05); #1;
    tests++;
    if (IN_READY !== 1'b0) begin fails++; $display("FAIL flush_in_ready: got %b want 0", IN_READY); end
    step(); FLUSH = 1'b0;
    tests++;
    if ({OUT_VALID, DEC_COUNT} !== {1'b0, 16'd0}) begin
      fails++; $display("FAIL flush_arg: got valid=%b cnt=%0d want 0 0", OUT_VALID, DEC_COUNT);
    end
    step(); drive(1'b0, 8'h00);
    tests++;
    if ({OUT_VALID, OUT_OPCODE, OUT_ARGS, OUT_NARGS} !== {1'b1, 8'h05, 16'h0000, 2'd0}) begin
      fails++;
      $display("FAIL flush_after: got valid=%b op=%h args=%h nargs=%0d want 1 05 0000 0",
               OUT_VALID, OUT_OPCODE, OUT_ARGS, OUT_NARGS);
    end
    FLUSH = 1'b1; step(); FLUSH = 1'b0;
    tests++;
    if ({OUT_VALID, DEC_COUNT} !== {1'b0, 16'd0}) begin
      fails++; $display("FAIL flush_hold: got valid=%b cnt=%0d want 0 0", OUT_VALID, DEC_COUNT);
    end
    // asynchronous reset in the middle of an argument sequence
    drive(1'b1, 8'h21); step();
    drive(1'b1, 8'hAB); step();
    drive(1'b0, 8'h00);
    RST = 1'b1; #1;
    tests++;
    if ({OUT_VALID, OUT_OPCODE, OUT_ARGS, OUT_NARGS, OUT_ILLEGAL, DEC_COUNT} !== 44'h0) begin
      fails++;
      $display("FAIL rst_mid_arg: got valid=%b op=%h args=%h nargs=%0d ill=%b cnt=%0d want all 0",
               OUT_VALID, OUT_OPCODE, OUT_ARGS, OUT_NARGS, OUT_ILLEGAL, DEC_COUNT);
    end
    RST = 1'b0;
    step();
    drive(1'b1, 8'h05); step();
    drive(1'b0, 8'h00);
    tests++;
    if ({OUT_VALID, OUT_OPCODE, OUT_ARGS} !== {1'b1, 8'h05, 16'h0000}) begin
      fails++;
      $display("FAIL rst_discard: got valid=%b op=%h args=%h want 1 05 0000", OUT_VALID, OUT_OPCODE, OUT_ARGS);
    end
  endtask

  task automatic test_random;
    exp_t       exp_q[$];
    logic [7:0] bq[$];
    exp_t       e;
    int         n_instr = 150;
    do_reset();
    // Reference: build the byte stream and its expected decode directly
    // from the group length table and illegal mask.
    for (int k = 0; k < n_instr; k++) begin
      logic [7:0] op, b;
      logic [2:0] g;
      logic [1:0] len;
      op  = 8'($urandom_range(255));
      g   = op[7:5];
      len = 2'((LEN_MAP_REF >> (2 * g)) & 16'h3);
      e.op    = op;
      e.ill   = ILL_REF[g] || (len > 2'd2);
      e.nargs = e.ill ? 2'd0 : len;
      e.args  = 16'h0;
      bq.push_back(op);
      for (int j = 0; j < e.nargs; j++) begin
        b = 8'($urandom_range(255));
        e.args = (e.args << 8) | {8'h00, b};
        bq.push_back(b);
      end
      exp_q.push_back(e);
    end
    for (int cyc = 0; cyc < 4000 && exp_q.size() > 0; cyc++) begin
      IN_VALID  = (bq.size() > 0) && ($urandom_range(3) != 0);
      IN_DATA   = (bq.size() > 0) ? bq[0] : 8'h00;
      OUT_READY = ($urandom_range(2) != 0);
      #1;
      tests++;
      if (IN_READY !== (!OUT_VALID || OUT_READY)) begin
        fails++;
        $display("FAIL rand_in_ready: cycle %0d got %b want %b", cyc, IN_READY, (!OUT_VALID || OUT_READY));
      end
      if (OUT_VALID && OUT_READY) begin
        e = exp_q.pop_front();
        tests++;
        if ({OUT_OPCODE, OUT_GROUP, OUT_ARGS, OUT_NARGS, OUT_ILLEGAL} !== {e.op, e.op[7:5], e.args, e.nargs, e.ill}) begin
          fails++;
          $display("FAIL rand_decode: got op=%h grp=%0d args=%h nargs=%0d ill=%b want op=%h grp=%0d args=%h nargs=%0d ill=%b",
                   OUT_OPCODE, OUT_GROUP, OUT_ARGS, OUT_NARGS, OUT_ILLEGAL,
                   e.op, e.op[7:5], e.args, e.nargs, e.ill);
        end
      end
      if (IN_VALID && IN_READY) void'(bq.pop_front());
      step();
    end
    drive(1'b0, 8'h00); OUT_READY = 1'b0;
    tests++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL rand_timeout: got %0d pending want 0", exp_q.size());
    end
    tests++;
    if (DEC_COUNT !== 16'(n_instr)) begin
      fails++; $display("FAIL rand_count: got %0d want %0d", DEC_COUNT, n_instr);
    end
  endtask

  task automatic test_wrap;
    logic        rdy_ok = 1'b1;
    logic [15:0] cnt_ffff = 16'h0;
    do_reset();
    OUT_READY = 1'b1; drive(1'b1, 8'h05);
    // first edge takes the first opcode, every later edge also hands one off
    for (int i = 0; i < 65537; i++) begin
      if (IN_READY !== 1'b1) rdy_ok = 1'b0;
      step();
      if (i == 65535) cnt_ffff = DEC_COUNT;
    end
    drive(1'b0, 8'h00); OUT_READY = 1'b0;
    tests++;
    if (rdy_ok !== 1'b1) begin fails++; $display("FAIL wrap_sustained_ready: got 0 want 1"); end
    tests++;
    if (cnt_ffff !== 16'hFFFF) begin fails++; $display("FAIL wrap_max: got %h want ffff", cnt_ffff); end
    tests++;
    if ({OUT_VALID, DEC_COUNT} !== {1'b1, 16'h0000}) begin
      fails++; $display("FAIL wrap_zero: got valid=%b cnt=%h want 1 0000", OUT_VALID, DEC_COUNT);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_illegal();
    test_flush();
    test_random();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_fetch_decoder.md
Name: instr_fetch_decoder

Overview:
- Byte-serial successor to the single-cycle instruction decoder.
- Accepts instruction bytes from the fetch path over a valid/ready stream and assembles opcode plus variable-length arguments.
- Classifies each instruction by group and presents one decoded instruction per handshake to the execute stage.
- Group width, data width, argument length per group and illegal groups are parameters; a per-group length table replaces the fixed 24-bit word.

Parameters:
- DATA_W, 8: width of one fetched byte/word; opcode width.
- GROUP_W, 3: opcode MSBs forming the group field; must be ≤ DATA_W.
- ARG_BYTES, 2: maximum argument words per instruction, 1..3.
- LEN_MAP, 16'b00_00_00_00_10_01_10_00: 2 bits per group (group 0 in LSBs), giving the number of argument words. Defaults: misc=0, transfer=2, arithmetic=1, branch=2, groups 4-7=0.
- ILLEGAL_MASK, 8'b1111_0000: a 1 marks the group as illegal.

Ports:
- CLK, input, 1: CPU clock, rising edge.
- RST, input, 1: asynchronous, active-high reset.
- FLUSH, input, 1: synchronous discard of any partial or held instruction.
- IN_VALID, input, 1: fetch byte valid.
- IN_READY, output, 1: decoder can accept IN_DATA.
- IN_DATA, input, DATA_W: fetched byte.
- OUT_VALID, output, 1: decoded instruction valid.
- OUT_READY, input, 1: execute stage accepts.
- OUT_OPCODE, output, DATA_W: opcode byte.
- OUT_GROUP, output, GROUP_W: OUT_OPCODE[DATA_W-1 -: GROUP_W].
- OUT_ARGS, output, ARG_BYTES*DATA_W: argument words, right-aligned.
- OUT_NARGS, output, 2: argument count from LEN_MAP.
- OUT_ILLEGAL, output, 1: group flagged in ILLEGAL_MASK.
- DEC_COUNT, output, 16: decoded-instruction counter.

Behaviour:
- Reset (async, RST=1): state=OPC, all outputs 0 (OUT_* registers, DEC_COUNT=0, OUT_VALID=0); IN_READY=1 once RST deasserts. Reset mid-instruction discards the partial instruction.
- Byte transfer when IN_VALID&&IN_READY; output transfer when OUT_VALID&&OUT_READY.
- IN_READY = (state!=HOLD) || OUT_READY. This is a combinational bypass so back-to-back instructions sustain one byte per cycle.
- States: OPC (await opcode), ARG (collecting arguments), HOLD (output valid).
- OPC, on byte:
  - Latch the opcode; clear the argument shift register.
  - remaining = LEN_MAP[2*group +: 2].
  - If group is illegal: remaining forced to 0, ILLEGAL=1.
  - If LEN_MAP entry > ARG_BYTES: treat as illegal, remaining 0.
  - remaining==0 → HOLD; else → ARG.
- ARG, on byte:
  - args <= (args << DATA_W) | IN_DATA, truncated to ARG_BYTES*DATA_W; remaining--.
  - When remaining reaches 0 → HOLD.
  - Net effect: the last byte sits in the LSBs and unused high words stay 0.
- HOLD:
  - OUT_VALID=1; outputs stable until handshake.
  - On handshake: DEC_COUNT++ (wraps 0xFFFF→0).
  - If the same cycle carries an input byte, it is treated as a new opcode (same rules as OPC) with the next state chosen accordingly. Otherwise → OPC.
- Latency: OUT_VALID rises the cycle after the final byte of an instruction is accepted.
- Outputs are registered; OUT_* change only on entering HOLD or on a HOLD→HOLD bypass.
- FLUSH=1 (priority over all transfers that cycle):
  - next state OPC, OUT_VALID=0, no byte consumed (IN_READY=0 during FLUSH), DEC_COUNT unchanged even if OUT_READY=1.
- OUT_READY=1 while OUT_VALID=0 has no effect.
- IN_VALID=0 in ARG stalls indefinitely with partial args retained.

Test Plan:
- Reset, then bytes 0x05 (group 0), OUT_READY=1 → next cycle OUT_VALID=1, OPCODE=0x05, NARGS=0, ARGS=0x0000, ILLEGAL=0; DEC_COUNT=1 after handshake.
- Bytes 0x21,0xAB,0xCD back-to-back → OUT_VALID one cycle after 0xCD, GROUP=1, ARGS=0xABCD, NARGS=2.
- 0x41,0x7F (arithmetic, 1 arg) with OUT_READY=0 for 5 cycles, then 0x22,0x12,0x34 offered → ARGS=0x007F held, IN_READY=0 while stalled. On OUT_READY=1, 0x22 is accepted the same cycle; next instruction decodes to ARGS=0x1234.
- Opcode 0x9C (group 4) → single-byte, ILLEGAL=1, NARGS=0; the following byte 0x00 is decoded as a new opcode.
- 0x21,0x11 then FLUSH=1 → OUT_VALID stays 0, DEC_COUNT unchanged. Next 0x05 decodes as misc. Repeat with RST pulsed mid-ARG → all outputs 0 asynchronously.
- 65536 single-byte instructions with OUT_READY=1 → DEC_COUNT wraps to 0, one instruction per cycle sustained via bypass.
